// File: rtl/upower_alu_pkg.sv
// Shared uPower ALU definitions: opcode/XO constants, the ALU control code and
// the instruction-to-control decode used by the control queue and the ALU.
package upower_alu_pkg;

    localparam logic [5:0] OP_LW    = 6'd32;
    localparam logic [5:0] OP_SW    = 6'd36;
    localparam logic [5:0] OP_ADDI  = 6'd14;
    localparam logic [5:0] OP_BEQ   = 6'd19;
    localparam logic [5:0] OP_ORI   = 6'd15;
    localparam logic [5:0] OP_ANDI  = 6'd28;
    localparam logic [5:0] OP_XORI  = 6'd26;
    localparam logic [5:0] OP_RTYPE = 6'd31;

    localparam logic [9:0] XO_AND   = 10'd28;
    localparam logic [9:0] XO_OR    = 10'd444;
    localparam logic [9:0] XO_ADD   = 10'd266;
    localparam logic [9:0] XO_SUB   = 10'd40;
    localparam logic [9:0] XO_XOR   = 10'd316;
    localparam logic [9:0] XO_NAND  = 10'd476;
    localparam logic [9:0] XO_SLD   = 10'd27;
    localparam logic [9:0] XO_SRD   = 10'd539;
    localparam logic [9:0] XO_SRAD  = 10'd794;
    localparam logic [9:0] XO_EXTSW = 10'd986;
    localparam logic [9:0] XO_CMP   = 10'd0;

    typedef enum logic [3:0] {
        ALU_AND   = 4'd0,
        ALU_OR    = 4'd1,
        ALU_ADD   = 4'd2,
        ALU_XOR   = 4'd3,
        ALU_NAND  = 4'd4,
        ALU_SUB   = 4'd6,
        ALU_SLD   = 4'd7,
        ALU_SRD   = 4'd8,
        ALU_SRAD  = 4'd9,
        ALU_EXTSW = 4'd10,
        ALU_CMP   = 4'd11
    } alu_ctrl_e;

    typedef struct packed {
        alu_ctrl_e ctrl;
        logic      illegal;
    } alu_dec_t;

    // Unrecognised encodings decode to ctrl=AND (0) with the illegal flag set.
    function automatic alu_dec_t alu_decode(input logic [5:0] opcode,
                                            input logic [9:0] xo);
        alu_dec_t dec;
        dec.ctrl    = ALU_AND;
        dec.illegal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_ADDI: dec.ctrl = ALU_ADD;
            OP_BEQ:                dec.ctrl = ALU_SUB;
            OP_ORI:                dec.ctrl = ALU_OR;
            OP_ANDI:               dec.ctrl = ALU_AND;
            OP_XORI:               dec.ctrl = ALU_XOR;
            OP_RTYPE: begin
                case (xo)
                    XO_AND:   dec.ctrl = ALU_AND;
                    XO_OR:    dec.ctrl = ALU_OR;
                    XO_ADD:   dec.ctrl = ALU_ADD;
                    XO_SUB:   dec.ctrl = ALU_SUB;
                    XO_XOR:   dec.ctrl = ALU_XOR;
                    XO_NAND:  dec.ctrl = ALU_NAND;
                    XO_SLD:   dec.ctrl = ALU_SLD;
                    XO_SRD:   dec.ctrl = ALU_SRD;
                    XO_SRAD:  dec.ctrl = ALU_SRAD;
                    XO_EXTSW: dec.ctrl = ALU_EXTSW;
                    XO_CMP:   dec.ctrl = ALU_CMP;
                    default:  dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/upower_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; the head entry reads as zero when
// empty so the consumer never sees uninitialised storage.
module upower_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are live, and rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/upower_alu_ctrl_q.sv
// Registered ALU-control decoder: decodes each accepted instruction, queues the
// control word with its tag, and counts illegal decodes for debug.
module upower_alu_ctrl_q
    import upower_alu_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [9:0]        in_xo,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_illegal,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  ill_count,
    input  logic              count_clr
);

    localparam int ENTRY_W = 1 + 4 + TAG_W;

    alu_dec_t           dec;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic [3:0]         head_ctrl;

    assign dec      = alu_decode(in_opcode, in_xo);
    assign wr_entry = {dec.illegal, dec.ctrl, in_tag};

    // in_ready depends only on occupancy, so a pop never frees a slot in the same cycle.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    upower_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign out_illegal = head[ENTRY_W-1];
    assign head_ctrl   = head[TAG_W +: 4];
    assign out_ctrl    = CTRL_W'(head_ctrl);
    assign out_tag     = head[TAG_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ill_count <= '0;
        end else if (count_clr) begin
            ill_count <= '0;
        end else if (push && dec.illegal && (ill_count != {CNT_W{1'b1}})) begin
            ill_count <= ill_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_upower_alu_ctrl_q.sv
// Directed bench for upower_alu_ctrl_q: a decode vector table streamed at full
// rate, then hand-written backpressure, counter saturation and reset sequences.
module tb_upower_alu_ctrl_q;

    localparam int CTRL_W = 4;
    localparam int DEPTH  = 2;
    localparam int TAG_W  = 5;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [9:0]        in_xo;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_illegal;
    logic [TAG_W-1:0]  out_tag;
    logic [CNT_W-1:0]  ill_count;
    logic              count_clr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0] op;
        logic [9:0] xo;
        logic [4:0] tag;
        logic [3:0] ctrl;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    upower_alu_ctrl_q #(
        .CTRL_W (CTRL_W),
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_xo       (in_xo),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_illegal (out_illegal),
        .out_tag     (out_tag),
        .ill_count   (ill_count),
        .count_clr   (count_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input int op, input int xo, input int tag, input int ctrl, input bit ill);
        vec_t v;
        v.op   = 6'(op);
        v.xo   = 10'(xo);
        v.tag  = 5'(tag);
        v.ctrl = 4'(ctrl);
        v.ill  = ill;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input int xo, input int tag);
        in_valid  = 1'b1;
        in_opcode = 6'(op);
        in_xo     = 10'(xo);
        in_tag    = TAG_W'(tag);
    endtask

    task automatic check_head(input string name, input int ctrl, input bit ill, input int tag);
        check({name, ".valid"}, 32'(out_valid), 32'd1);
        check({name, ".ctrl"}, 32'(out_ctrl), 32'(ctrl));
        check({name, ".illegal"}, 32'(out_illegal), 32'(ill));
        check({name, ".tag"}, 32'(out_tag), 32'(tag));
    endtask

    int exp_cnt;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_xo     = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        count_clr = 1'b0;

        add(31, 444, 3, 1, 0);
        add(14,   0, 4, 2, 0);
        add(19,   0, 5, 6, 0);
        add(15,   0, 6, 1, 0);
        add(28,   0, 7, 0, 0);
        add(26,   0, 8, 3, 0);
        add(31,   0, 9, 11, 0);
        add(32,   0, 10, 2, 0);
        add(36,   0, 11, 2, 0);
        add(14, 999, 12, 2, 0);
        add(31,  28, 13, 0, 0);
        add(31, 266, 14, 2, 0);
        add(31,  40, 15, 6, 0);
        add(31, 316, 16, 3, 0);
        add(31, 476, 17, 4, 0);
        add(31,  27, 18, 7, 0);
        add(31, 539, 19, 8, 0);
        add(31, 794, 20, 9, 0);
        add(31, 986, 21, 10, 0);
        add(31, 999, 22, 0, 1);
        add( 7,   0, 23, 0, 1);
        add(28, 444, 24, 0, 0);

        // Reset state while held.
        step();
        step();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_ctrl", 32'(out_ctrl), 32'd0);
        check("rst.out_illegal", 32'(out_illegal), 32'd0);
        check("rst.out_tag", 32'(out_tag), 32'd0);
        check("rst.ill_count", 32'(ill_count), 32'd0);
        rst = 1'b0;
        step();

        // Table: one push per cycle with out_ready=1; each entry appears next cycle.
        out_ready = 1'b1;
        exp_cnt   = 0;
        foreach (vecs[i]) begin
            check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
            drive(vecs[i].op, vecs[i].xo, vecs[i].tag);
            if (vecs[i].ill && exp_cnt < 3) exp_cnt++;
            step();
            check_head($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].ill, vecs[i].tag);
        end
        in_valid = 1'b0;
        step();
        check("drain.out_valid", 32'(out_valid), 32'd0);
        check("table.ill_count", 32'(ill_count), 32'(exp_cnt));
        check("table.ill_count_abs", 32'(ill_count), 32'd2);

        // Backpressure: fill, hold a third entry, then drain in order.
        out_ready = 1'b0;
        drive(14, 0, 10);
        step();
        check("bp.ready_after1", 32'(in_ready), 32'd1);
        drive(19, 0, 11);
        step();
        check("bp.ready_after2", 32'(in_ready), 32'd0);
        check_head("bp.headA", 2, 0, 10);
        drive(15, 0, 12);
        step();
        check("bp.ready_held", 32'(in_ready), 32'd0);
        check_head("bp.headA_stable", 2, 0, 10);
        out_ready = 1'b1;
        step();
        check_head("bp.headB", 6, 0, 11);
        check("bp.ready_after_pop", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_head("bp.headC", 1, 0, 12);
        step();
        check("bp.empty", 32'(out_valid), 32'd0);
        check("bp.ill_count", 32'(ill_count), 32'd2);

        // Counter saturation and clear priority.
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        check("sat.cleared", 32'(ill_count), 32'd0);
        exp_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            drive(40 + k, 0, k);
            if (exp_cnt < 3) exp_cnt++;
            step();
            check($sformatf("sat.push%0d", k), 32'(ill_count), 32'(exp_cnt));
            check_head($sformatf("sat.entry%0d", k), 0, 1, k);
        end
        check("sat.max", 32'(ill_count), 32'd3);
        drive(63, 0, 9);
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        in_valid  = 1'b0;
        check("sat.clr_wins", 32'(ill_count), 32'd0);
        check_head("sat.entry5_enqueued", 0, 1, 9);
        step();

        // Reset mid-stream with two illegal entries buffered.
        out_ready = 1'b0;
        drive(7, 0, 1);
        step();
        drive(31, 999, 2);
        step();
        in_valid = 1'b0;
        check("mid.full", 32'(in_ready), 32'd0);
        check("mid.count", 32'(ill_count), 32'd2);
        rst = 1'b1;
        #1;
        check("mid.rst_out_valid", 32'(out_valid), 32'd0);
        check("mid.rst_in_ready", 32'(in_ready), 32'd1);
        check("mid.rst_count", 32'(ill_count), 32'd0);
        check("mid.rst_tag", 32'(out_tag), 32'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("mid.no_stale%0d", k), 32'(out_valid), 32'd0);
        end
        drive(31, 0, 30);
        step();
        in_valid = 1'b0;
        check_head("mid.fresh", 11, 0, 30);
        step();
        check("mid.final_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/upower_alu_ctrl_q.md
# upower_alu_ctrl_q

Registered, flow-controlled ALU-control decoder for the uPower datapath. It accepts the primary opcode and the 10-bit extended opcode (XO) of each instruction, along with a tag, through a valid/ready handshake. It decodes them to an ALU control word with an extended operation set and an illegal-instruction flag, and buffers results in a small FIFO so decode can run decoupled from the execute stage. A saturating counter records illegal decodes for debug.

## Interface
Parameters:
- CTRL_W, 4: width of out_ctrl; must be ≥4; codes are zero-extended.
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- TAG_W, 5: width of the pass-through instruction tag.
- CNT_W, 8: width of the illegal-decode counter.

Ports:
- clk, in, 1: single clock; all state on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: input entry valid.
- in_ready, out, 1: block can accept an entry.
- in_opcode, in, 6: primary opcode.
- in_xo, in, 10: extended opcode (meaningful for opcode 31 only).
- in_tag, in, TAG_W: tag carried unchanged to the output.
- out_valid, out, 1: head entry valid.
- out_ready, in, 1: consumer takes the head entry.
- out_ctrl, out, CTRL_W: ALU control code.
- out_illegal, out, 1: head entry did not decode.
- out_tag, out, TAG_W: tag of the head entry.
- ill_count, out, CNT_W: saturating count of illegal entries accepted.
- count_clr, in, 1: synchronous clear of ill_count.

## Operation
- Control codes: AND=0, OR=1, ADD=2, XOR=3, NAND=4, SUB=6, SLD=7, SRD=8, SRAD=9, EXTSW=10, CMP=11.
- Primary decode:
  - 32 (lw), 36 (sw), 14 (addi) → ADD.
  - 19 (beq) → SUB.
  - 15 (ori) → OR.
  - 28 (andi) → AND.
  - 26 (xori) → XOR.
  - 31 → XO decode.
- XO decode:
  - 28 → AND; 444 → OR; 266 → ADD; 40 → SUB; 316 → XOR.
  - 476 → NAND; 27 → SLD; 539 → SRD; 794 → SRAD; 986 → EXTSW; 0 → CMP.
- Any other opcode, or opcode 31 with any other XO, is illegal:
  - ctrl=0 and illegal=1.
  - The entry is still enqueued; it is never dropped.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = !full. There is no combinational path from out_ready to in_ready.
  - When the FIFO is full, a simultaneous pop does not allow a same-cycle push.
- When neither full nor empty, push and pop can occur in the same cycle; occupancy is unchanged.
- Output fields (out_ctrl, out_illegal, out_tag) are driven from the head entry and are held stable while out_valid && !out_ready.
- ill_count:
  - Increments on each accepted illegal push.
  - Saturates at 2^CNT_W−1.
  - count_clr has priority over a same-cycle increment; the result is 0.

## Timing
- Reset values (asynchronous):
  - FIFO empty: out_valid=0, in_ready=1.
  - out_ctrl=0, out_illegal=0, out_tag=0.
  - ill_count=0.
- Latency: an entry pushed in cycle N appears with out_valid=1 in cycle N+1 when the FIFO was empty. Decode is combinational ahead of the FIFO write; the output is registered.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Pointers are log2(DEPTH)+1 bits wide; they wrap naturally. full/empty are derived from the MSB comparison.
- Reset asserted mid-stream discards all entries immediately. No output handshake completes in that cycle.

## Structure
- Package upower_alu_pkg holds:
  - Opcode constants (LW, SW, ADDI, BEQ, ORI, ANDI, XORI, RTYPE).
  - XO constants.
  - The 4-bit ALU control code enum.
  - The decode function used by this block and the ALU.
- Sub-module upower_sync_fifo (parameters WIDTH, DEPTH): the storage, pointers, full/empty.
- The top level holds the decode, the counter, and the handshake glue.

## Test plan
- Reset, then push opcode 31/XO 444 tag 3 with out_ready=1 → next cycle: out_valid=1, out_ctrl=1, out_illegal=0, out_tag=3.
- Back-to-back pushes of 14, 19, 15, 28, 26, then 31 with XO 0, with out_ready=1 → ctrl sequence 2, 6, 1, 0, 3, 11, one per cycle, in order.
- out_ready=0, DEPTH=2, push 3 entries → in_ready=0 after 2 pushes and the third is held. Raise out_ready → entries drain in order, then the third is accepted.
- Push opcode 31/XO 999, then opcode 7 → both outputs ctrl=0, illegal=1; ill_count=2.
- CNT_W=2, push 5 illegal entries → ill_count saturates at 3. Pulse count_clr together with a 6th illegal push → ill_count=0.
- Assert rst with 2 entries buffered → out_valid=0 and in_ready=1 immediately, ill_count=0, and no stale entry appears after release.
